// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory bus responders: FSM encoding,
// bus width, wait-state limit and the address range helper.
package mem_bus_pkg;

    localparam int BUS_W    = 16;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // True when no byte-address bit above the word index is set.
    function automatic logic addr_in_range(input logic [BUS_W-1:0] addr,
                                           input int idx_w);
        return (addr >> (idx_w + 1)) == '0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 16 single-port RAM with one write port and a registered read port.
// The read register can be cleared so out-of-range reads return zero.
module mem_array
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    addr,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] rdata
);

    logic [BUS_W-1:0] mem_q [DEPTH];
    logic [BUS_W-1:0] rdata_q;
    logic [BUS_W-1:0] rdata_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_clr) begin
            rdata_d = '0;
        end else if (rd_en) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Memory bus responder: captures one stb/we request, waits WAIT_STATES cycles,
// commits the read or write into mem_array and pulses ack_o for one cycle.
//
// state | meaning
// IDLE  | no request in progress, stb_i sampled every edge
// WAIT  | request captured, counting down wait states
// ACK   | access committed, ack_o high for this single cycle
module wb_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [BUS_W-1:0] addr_i,
    input  logic [BUS_W-1:0] data_i,
    output logic [BUS_W-1:0] data_o,
    output logic             ack_o,
    output logic             busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam state_t CAPTURE_NEXT = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [BUS_W-1:0]   addr_q, addr_d;
    logic [BUS_W-1:0]   wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    logic               commit;
    logic               cur_we;
    logic [BUS_W-1:0]   cur_addr;
    logic [BUS_W-1:0]   cur_wdata;
    logic               cur_in_range;
    logic               mem_wr_en;
    logic               mem_rd_en;
    logic               mem_rd_clr;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (stb_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_INIT;
                    state_d = CAPTURE_NEXT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With no wait states the commit edge is also the capture edge, so the
    // live bus inputs are used instead of the capture registers.
    always_comb begin
        commit       = (state_d == ST_ACK) && (state_q != ST_ACK);
        cur_we       = (state_q == ST_IDLE) ? we_i   : we_q;
        cur_addr     = (state_q == ST_IDLE) ? addr_i : addr_q;
        cur_wdata    = (state_q == ST_IDLE) ? data_i : wdata_q;
        cur_in_range = addr_in_range(cur_addr, AW);
        mem_wr_en    = commit &&  cur_we &&  cur_in_range;
        mem_rd_en    = commit && !cur_we &&  cur_in_range;
        mem_rd_clr   = commit && !cur_we && !cur_in_range;
        ack_d        = (state_d == ST_ACK);
        busy_d       = (state_d != ST_IDLE);
    end

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk    (sys_clk),
        .rst_n  (sys_rst),
        .wr_en  (mem_wr_en),
        .rd_en  (mem_rd_en),
        .rd_clr (mem_rd_clr),
        .addr   (cur_addr[AW:1]),
        .wdata  (cur_wdata),
        .rdata  (data_o)
    );

    assign ack_o  = ack_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (0, 1 and 3 wait states) checked
// against a word-array model with directed and random bus transfers.
module tb_wb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        stb  [3];
    logic        we   [3];
    logic [15:0] addr [3];
    logic [15:0] wdat [3];
    logic [15:0] dout [3];
    logic        ack  [3];
    logic        busy [3];

    int errors = 0;
    int checks = 0;

    logic [15:0] model_mem [3][256];
    logic [15:0] last_rd   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_mem_responder #(
            .DEPTH       (256),
            .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .sys_clk (clk),
            .sys_rst (rst_n),
            .stb_i   (stb[g]),
            .we_i    (we[g]),
            .addr_i  (addr[g]),
            .data_i  (wdat[g]),
            .data_o  (dout[g]),
            .ack_o   (ack[g]),
            .busy_o  (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte addresses below 2*DEPTH map to word a/2; anything else reads as zero
    // and never writes.
    task automatic model_apply(input int i, input bit w, input logic [15:0] a,
                               input logic [15:0] d);
        int ai;
        ai = int'(a);
        if (ai < 512) begin
            if (w) model_mem[i][ai / 2] = d;
            else   last_rd[i] = model_mem[i][ai / 2];
        end else if (!w) begin
            last_rd[i] = 16'h0000;
        end
    endtask

    // One transfer; stb is dropped and the other inputs scrambled right after
    // the capture edge, which must not affect the outcome.
    task automatic txn(input int i, input bit w, input logic [15:0] a,
                       input logic [15:0] d, input string tag);
        int edges;
        bit got;
        @(negedge clk);
        stb[i] = 1'b1; we[i] = w; addr[i] = a; wdat[i] = d;
        model_apply(i, w, a, d);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                stb[i] = 1'b0; we[i] = ~w; addr[i] = a ^ 16'h0002; wdat[i] = ~d;
            end
            if (ack[i]) got = 1'b1;
            else        chk($sformatf("%s busy_wait", tag), 32'(busy[i]), 32'd1);
        end
        chk($sformatf("%s latency", tag), got ? 32'(edges) : 32'd0, 32'(ws_of(i) + 1));
        chk($sformatf("%s data_at_ack", tag), 32'(dout[i]), 32'(last_rd[i]));
        chk($sformatf("%s busy_at_ack", tag), 32'(busy[i]), 32'd1);
        @(posedge clk); #1;
        chk($sformatf("%s ack_single", tag), 32'(ack[i]), 32'd0);
        chk($sformatf("%s busy_after", tag), 32'(busy[i]), 32'd0);
        chk($sformatf("%s data_held", tag), 32'(dout[i]), 32'(last_rd[i]));
    endtask

    initial begin
        logic [15:0] e0, e1;
        for (int i = 0; i < 3; i++) begin
            stb[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
            last_rd[i] = 16'h0000;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset ack[%0d]", i),  32'(ack[i]),  32'd0);
            chk($sformatf("reset busy[%0d]", i), 32'(busy[i]), 32'd0);
            chk($sformatf("reset data[%0d]", i), 32'(dout[i]), 32'd0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 256; w++)
                txn(i, 1'b1, 16'(w * 2), 16'($urandom), $sformatf("preload%0d", i));

        // WS=1: write then read back
        txn(1, 1'b1, 16'h0010, 16'hBEEF, "ws1 write");
        txn(1, 1'b0, 16'h0010, 16'h0000, "ws1 read");
        chk("ws1 beef", 32'(dout[1]), 32'h0000BEEF);

        // WS=0: back-to-back reads with stb held
        txn(0, 1'b1, 16'h0000, 16'h1111, "ws0 w0");
        txn(0, 1'b1, 16'h0002, 16'h2222, "ws0 w2");
        e0 = model_mem[0][0];
        e1 = model_mem[0][1];
        @(negedge clk);
        stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0000;
        @(posedge clk); #1;
        chk("b2b ack1", 32'(ack[0]), 32'd1);
        chk("b2b data1", 32'(dout[0]), 32'(e0));
        addr[0] = 16'h0002;
        @(posedge clk); #1;
        chk("b2b no_double", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        chk("b2b ack2", 32'(ack[0]), 32'd1);
        chk("b2b data2", 32'(dout[0]), 32'(e1));
        stb[0] = 1'b0;
        @(posedge clk); #1;
        chk("b2b ack_end", 32'(ack[0]), 32'd0);
        chk("b2b busy_end", 32'(busy[0]), 32'd0);
        last_rd[0] = e1;

        // WS=3: inputs change after capture, original address must win
        txn(2, 1'b1, 16'h0050, 16'h5050, "ws3 wa");
        txn(2, 1'b1, 16'h0052, 16'h5252, "ws3 wb");
        txn(2, 1'b0, 16'h0050, 16'h0000, "ws3 ra");
        chk("ws3 orig_addr", 32'(dout[2]), 32'h00005050);

        // Out of range on every instance
        for (int i = 0; i < 3; i++) begin
            txn(i, 1'b0, 16'h0400, 16'h0000, $sformatf("oor rd[%0d]", i));
            chk($sformatf("oor zero[%0d]", i), 32'(dout[i]), 32'd0);
            txn(i, 1'b1, 16'h0400, 16'h1234, $sformatf("oor wr[%0d]", i));
            txn(i, 1'b0, 16'h0000, 16'h0000, $sformatf("oor w0[%0d]", i));
        end

        // addr bit 0 ignored
        txn(1, 1'b1, 16'h0021, 16'hA5A5, "odd write");
        txn(1, 1'b0, 16'h0020, 16'h0000, "odd read");
        chk("odd a5a5", 32'(dout[1]), 32'h0000A5A5);

        // Reset in the middle of a WS=3 write: write must be discarded
        txn(2, 1'b0, 16'h0040, 16'h0000, "pre_rst rd");
        @(negedge clk);
        stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0030; wdat[2] = 16'hDEAD;
        @(posedge clk); #1;
        stb[2] = 1'b0;
        chk("rst busy_wait1", 32'(busy[2]), 32'd1);
        @(posedge clk); #1;
        chk("rst busy_wait2", 32'(busy[2]), 32'd1);
        chk("rst no_ack_yet", 32'(ack[2]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_rst ack[%0d]", i),  32'(ack[i]),  32'd0);
            chk($sformatf("mid_rst busy[%0d]", i), 32'(busy[i]), 32'd0);
            chk($sformatf("mid_rst data[%0d]", i), 32'(dout[i]), 32'd0);
            last_rd[i] = 16'h0000;
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst idle", 32'(busy[2]), 32'd0);
        chk("post_rst no_ack", 32'(ack[2]), 32'd0);
        txn(2, 1'b0, 16'h0030, 16'h0000, "post_rst read");

        // Random traffic, about half of it out of range
        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 40; n++)
                txn(i, 1'($urandom), 16'($urandom_range(0, 16'h03FF)), 16'($urandom),
                    $sformatf("rnd%0d_%0d", i, n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
